act_mac_quant_4bit: RTL



---
 rtl/act_pkg.sv | 24 ++
 rtl/act_round_sat.sv | 29 ++
 rtl/act_mac_quant_4bit.sv | 94 +++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared constants and the saturating clamp used by the 4-bit activation stages.
package act_pkg;

    localparam int CODE_W   = 4;
    localparam int CODE_MIN = -8;
    localparam int CODE_MAX = 7;

    // Clamp a signed value into the two's-complement range of the given width (width <= 32).
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] value,
                                                     input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/act_round_sat.sv
// Rescales an accumulator sum by an arithmetic right shift with round-half-up,
// then saturates it to the signed activation code range.
module act_round_sat
    import act_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int SHIFT = 2
) (
    input  logic signed [ACC_W-1:0]  sum,
    output logic signed [CODE_W-1:0] code,
    output logic                     clamp
);

    localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) <<< (SHIFT - 1);

    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;
    logic signed [31:0]    wide;
    logic signed [31:0]    limited;

    // One extra bit of headroom keeps the rounding bias from wrapping at the positive limit.
    assign biased  = $signed({sum[ACC_W-1], sum}) + HALF;
    assign shifted = biased >>> SHIFT;
    assign wide    = 32'(shifted);
    assign limited = sat_clamp(wide, CODE_W);
    assign code    = limited[CODE_W-1:0];
    assign clamp   = (limited != wide);

endmodule

// File: rtl/act_mac_quant_4bit.sv
// Streamed signed dot-product accumulator that emits a rounded, saturated
// 4-bit code per vector through a one-entry valid/ready output register.
module act_mac_quant_4bit
    import act_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int ACC_W = 12,
    parameter int SHIFT = 2,
    parameter int LEN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [IN_W-1:0]   s_a,
    input  logic signed [IN_W-1:0]   s_b,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [CODE_W-1:0] m_code,
    output logic                     m_sat,
    output logic        [LEN_W-1:0]  m_len
);

    logic signed [ACC_W-1:0]  acc;
    logic        [LEN_W-1:0]  len;
    logic                     sat_sticky;

    logic signed [2*IN_W-1:0] product;
    logic signed [ACC_W:0]    sum_wide;
    logic signed [31:0]       sum_wide32;
    logic signed [31:0]       sum_sat32;
    logic signed [ACC_W-1:0]  sum_clamped;
    logic                     acc_ovf;
    logic        [LEN_W-1:0]  len_next;
    logic signed [CODE_W-1:0] code;
    logic                     out_clamp;
    logic                     beat;

    // The whole input stalls while an undelivered result is held.
    assign s_ready = !m_valid || m_ready;
    assign beat    = s_valid && s_ready;

    assign product     = s_a * s_b;
    assign sum_wide    = $signed({acc[ACC_W-1], acc}) + (ACC_W + 1)'(product);
    assign sum_wide32  = 32'(sum_wide);
    assign sum_sat32   = sat_clamp(sum_wide32, ACC_W);
    assign sum_clamped = sum_sat32[ACC_W-1:0];
    assign acc_ovf     = (sum_sat32 != sum_wide32);
    assign len_next    = (&len) ? len : len + 1'b1;

    act_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .sum   (sum_clamped),
        .code  (code),
        .clamp (out_clamp)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; a later assignment in the block wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            len        <= '0;
            sat_sticky <= 1'b0;
            m_valid    <= 1'b0;
            m_code     <= '0;
            m_sat      <= 1'b0;
            m_len      <= '0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (beat) begin
                if (s_last) begin
                    m_code     <= code;
                    m_sat      <= sat_sticky | acc_ovf | out_clamp;
                    m_len      <= len_next;
                    m_valid    <= 1'b1;
                    acc        <= '0;
                    len        <= '0;
                    sat_sticky <= 1'b0;
                end else begin
                    acc        <= sum_clamped;
                    len        <= len_next;
                    sat_sticky <= sat_sticky | acc_ovf;
                end
            end
        end
    end

endmodule
